sha_round_sequencer: RTL
========================

SHA_ROUND_SEQUENCER -- requirements
Module: sha_round_sequencer

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have byte_valid, input, 1, upstream message byte offered.
REQ-004 SHALL have byte_data, input, 8, upstream message byte, MSB-first order within the 512-bit block.
REQ-005 SHALL have byte_ready, output, 1, sequencer accepts a byte this cycle.
REQ-006 SHALL have first_block, input, 1, current block is first of message; sampled with byte 0.
REQ-007 SHALL have abort, input, 1, synchronous cancel of the current block.
REQ-008 SHALL have msg_byte, output, 8, byte to schedule stage; equal to byte_data (combinational pass-through).
REQ-009 SHALL have start, output, 1, schedule-stage load strobe; equals byte_valid AND byte_ready.
REQ-010 SHALL have sha_running, output, 1, schedule-stage shift/expand enable.
REQ-011 SHALL have state_counter, output, 6, round index t driving the K lookup.
REQ-012 SHALL have hash_init, output, 1, pulse: compression stage loads IV into a..h.
REQ-013 SHALL have hash_update, output, 1, pulse: compression stage adds a..h into H0..H7.
REQ-014 SHALL have done, output, 1, pulse: block digest complete.
REQ-015 SHALL have busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD, ROUND, FINAL, DONE with a 6-bit byte counter and the 6-bit round counter (state_counter).
REQ-017 IDLE/LOAD SHALL drive byte_ready=1 unless abort=1; all other states SHALL drive byte_ready=0.
REQ-018 Each accepted byte SHALL increment the byte counter; acceptance in IDLE SHALL move to LOAD and latch first_block.
REQ-019 Acceptance of byte 63 (counter=63) SHALL move to ROUND next cycle with state_counter=0; counter wraps to 0.
REQ-020 Gaps (byte_valid=0) in LOAD SHALL hold state and counter indefinitely; no timeout.
REQ-021 ROUND SHALL assert sha_running=1 for exactly 64 consecutive cycles with state_counter=0,1,...,63; sha_running=0 in all other states.
REQ-022 hash_init SHALL pulse for one cycle in the first ROUND cycle (state_counter=0) iff latched first_block=1.
REQ-023 After the state_counter=63 cycle the FSM SHALL enter FINAL for one cycle asserting hash_update=1.
REQ-024 FINAL SHALL be followed by DONE for one cycle asserting done=1, then IDLE.
REQ-025 Back-to-back block latency: byte 0 at cycle T, byte 63 at T+63, ROUND T+64..T+127, FINAL T+128, DONE T+129, byte_ready=1 at T+130.
REQ-026 state_counter SHALL hold 0 outside ROUND.
REQ-027 abort=1 in any state SHALL force byte_ready=0 and start=0 that cycle and return to IDLE next cycle with both counters cleared; no hash_update or done issued; abort wins over simultaneous byte_valid.
REQ-028 abort in IDLE SHALL have no effect beyond suppressing acceptance that cycle.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, byte/round counters 0, latched first_block 0, byte_ready=1 after release (combinational from IDLE), sha_running=0, state_counter=0, hash_init=0, hash_update=0, done=0, busy=0.
REQ-030 Reset mid-ROUND SHALL discard the block; first cycle after release behaves as IDLE.

Verification
REQ-031 64 back-to-back bytes 0x00..0x3F, first_block=1 -> 64 start pulses, hash_init at T+64, sha_running T+64..T+127, hash_update T+128, done T+129.
REQ-032 "abc" padded block (0x61,0x62,0x63,0x80,0x00...,0x18) with datapath attached -> H0 after done = 0xBA7816BF.
REQ-033 Second block with first_block=0 -> no hash_init, hash_update still at FINAL.
REQ-034 byte_valid toggled every other cycle -> 64 bytes accepted over 127 cycles, ROUND starts cycle after byte 63.
REQ-035 abort at state_counter=30 -> IDLE next cycle, state_counter=0, no done; next block runs normally.
REQ-036 rstn low at byte 40 -> all outputs at reset values, byte_ready=1 after release, counter restarts at 0.

Source files
------------

// File: rtl/sha_round_sequencer.sv
// Purpose: sequences one SHA-256 512-bit block: byte load, 64 compression rounds, digest update, done.
// Latency: byte 63 accepted at T+63 -> rounds T+64..T+127, hash_update T+128, done T+129, ready again T+130.
// Backpressure: byte_ready high only in IDLE/LOAD (dropped by abort); no bytes accepted while rounds run.
module sha_round_sequencer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       first_block,
    input  logic       abort,
    output logic [7:0] msg_byte,
    output logic       start,
    output logic       sha_running,
    output logic [5:0] state_counter,
    output logic       hash_init,
    output logic       hash_update,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] bcnt_q, bcnt_d;     // bytes of the current block accepted so far
    logic [5:0] rcnt_q, rcnt_d;     // round index t, only advances in ROUND
    logic       first_q, first_d;   // first_block captured with byte 0

    // State and counter registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            bcnt_q  <= 6'd0;
            rcnt_q  <= 6'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
        end
    end

    // Next-state logic and per-state strobes; abort overrides everything last.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        rcnt_d      = rcnt_q;
        first_d     = first_q;
        byte_ready  = 1'b0;
        sha_running = 1'b0;
        hash_init   = 1'b0;
        hash_update = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE, S_LOAD: begin
                byte_ready = ~abort;
                if (byte_valid && !abort) begin
                    bcnt_d = bcnt_q + 6'd1;
                    if (state_q == S_IDLE) begin
                        state_d = S_LOAD;
                        first_d = first_block;
                    end
                    // Last byte of the block: counter wraps, rounds start at t=0.
                    if (bcnt_q == 6'd63) begin
                        state_d = S_ROUND;
                        rcnt_d  = 6'd0;
                    end
                end
            end
            S_ROUND: begin
                sha_running = 1'b1;
                hash_init   = (rcnt_q == 6'd0) && first_q;
                rcnt_d      = rcnt_q + 6'd1;
                if (rcnt_q == 6'd63) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                hash_update = ~abort;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = ~abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over any acceptance in the same cycle and returns to a clean IDLE.
        if (abort) begin
            state_d = S_IDLE;
            bcnt_d  = 6'd0;
            rcnt_d  = 6'd0;
        end
    end

    assign start         = byte_valid & byte_ready;
    assign msg_byte      = byte_data;
    assign state_counter = rcnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule
